rr_prio_arbiter: RTL
====================

Name: rr_prio_arbiter

Overview:
- Parametrised, registered successor to the combinational 4:2 priority encoder.
- Arbitrates N request lines and issues a held grant (one-hot plus encoded index) until the requester releases or a hold timeout expires.
- Selectable fixed-priority mode (highest index wins, same order as the 4:2 encoder) or round-robin mode.
- Sits between request sources (DMA channels, bus masters) and a shared resource.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- IDX_W, $clog2(N), width of the encoded grant index; derived, never overridden.
- MAX_HOLD, 16, maximum consecutive cycles a single grant is held; 0 disables the timeout.
- CNT_W, 16, width of the hold counter; requires MAX_HOLD < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i high means requester i wants the resource.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- release  in  1  single-cycle pulse from the granted requester ending its grant.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IDX_W  binary index of the granted requester, registered.
- gnt_valid  out  1  high while any grant is active.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, sync release):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
  - State = IDLE, hold_cnt = 0, last_idx = 0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at a rising edge, go to GRANT on that edge.
  - gnt, gnt_idx and gnt_valid update on the same edge, so latency is 1 cycle from req sampled to grant visible.
  - If req == 0, stay in IDLE with outputs at their reset values.
- Winner selection (combinational from registered req sample and last_idx):
  - mode = 0: highest set index of req.
  - mode = 1: search starts at (last_idx - 1) mod N and descends, wrapping N-1 -> 0. The first set bit wins.
  - After reset, last_idx = 0, so the first round-robin search starts at N-1. The first grant is therefore identical in both modes.
  - last_idx updates to the winner on every grant, in both modes.
- GRANT:
  - gnt, gnt_idx and gnt_valid are held constant.
  - hold_cnt increments each cycle, starting at 1 on the grant edge.
  - Release conditions, checked each edge:
    - a) release = 1;
    - b) req[gnt_idx] = 0;
    - c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD.
  - On any release condition: go to IDLE, clear gnt, gnt_valid and hold_cnt. Set timeout = 1 for one cycle only if (c) alone caused the release.
  - When (a) or (b) coincides with (c), release is normal and timeout stays 0.
- Every grant is followed by one mandatory idle cycle with gnt_valid = 0, even if other requests are pending. The minimum grant period is therefore 2 cycles.
- mode changes while in GRANT take effect at the next arbitration.
- Requests asserted or dropped by non-granted requesters during GRANT have no effect until IDLE.
- gnt is always one-hot or zero. gnt_valid == |gnt.
- Reset asserted mid-grant clears all outputs immediately, without waiting for clk. The next grant after reset uses the fixed reset pointer, not pre-reset history.

Test Plan:
- Reset check: hold rst_n = 0 with req = 4'b1111 and clock running -> gnt = 0, gnt_valid = 0, timeout = 0. Deassert rst_n -> 1 cycle later gnt = 4'b1000, gnt_idx = 3.
- Fixed priority (mode = 0): req = 4'b1111, pulse release one cycle after each grant -> grant sequence idx 3, 3, 3, each separated by exactly 1 idle cycle. Then req = 4'b0110 -> idx 2.
- Round-robin (mode = 1): req = 4'b1111 held, release pulsed each grant -> idx 3, 2, 1, 0, 3. Then req = 4'b0101 with last_idx = 3 -> idx 2, then 0, then 2.
- Timeout (MAX_HOLD = 8): only req[1] high, no release -> gnt_valid high exactly 8 cycles, timeout pulses 1 cycle, 1 idle cycle, regrant idx 1.
- Requester drop: grant idx 2 active, req[2] falls at cycle 3 of grant -> gnt_valid = 0 after the next edge, timeout stays 0. Also check release coincident with the timeout edge -> timeout stays 0.
- Async reset mid-grant: drop rst_n between clock edges while gnt = 4'b0100 -> gnt = 0 immediately. After release, req = 4'b1111 in mode 1 -> first grant idx 3.

Source files
------------

// File: rtl/rr_prio_arbiter.sv
// -----------------------------------------------------------------------------
// rr_prio_arbiter
//
// Registered N-way arbiter for a shared resource. It is the successor of the
// combinational 4:2 priority encoder. A grant is issued one cycle after a
// request is seen in IDLE. The grant is held until the owner releases it,
// drops its request, or the MAX_HOLD timeout expires. Every grant is followed
// by one idle cycle.
//
// Winner selection:
//   mode = 0 : fixed priority, the highest set request index wins.
//   mode = 1 : round robin. The search starts at (last_idx - 1) mod N and
//              descends, wrapping from 0 to N-1.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[N]      request vector, bit i = requester i wants the resource
//   mode        0 = fixed priority, 1 = round robin (sampled in IDLE only)
//   release_in  single-cycle release pulse from the granted requester
//               (the name "release" is a reserved word in SystemVerilog)
//   gnt[N]      registered one-hot grant
//   gnt_idx     registered binary index of the granted requester
//   gnt_valid   high while a grant is active
//   timeout     one-cycle pulse when MAX_HOLD forcibly revoked a grant
//
// States:
//   state   | meaning
//   S_IDLE  | no grant; arbitrate on any set request
//   S_GRANT | grant held; watch release / request drop / hold timeout
// -----------------------------------------------------------------------------
module rr_prio_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 16,
  parameter  int CNT_W    = 16,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             release_in,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;

  logic [IDX_W-1:0]   win_idx;
  logic               rel_pulse, rel_drop, rel_hold;

  // Winner selection. The round-robin candidate is (last_idx - 1 - i) mod N;
  // since i < N the raw value never falls below -N, so a single +N corrects it.
  always_comb begin
    int   cand;
    logic found;
    win_idx = '0;
    cand    = 0;
    found   = 1'b0;
    if (!mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && req[i]) begin
          found   = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cand = int'(last_idx_q) - 1 - i;
        if (cand < 0) begin
          cand = cand + N;
        end
        if (!found && req[cand]) begin
          found   = 1'b1;
          win_idx = IDX_W'(cand);
        end
      end
    end
  end

  assign rel_pulse = release_in;
  assign rel_drop  = ~req[gnt_idx_q];
  assign rel_hold  = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    last_idx_d  = last_idx_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        if (|req) begin
          state_d          = S_GRANT;
          gnt_d[win_idx]   = 1'b1;
          gnt_idx_d        = win_idx;
          gnt_valid_d      = 1'b1;
          hold_cnt_d       = CNT_W'(1);
          last_idx_d       = win_idx;
        end
      end

      S_GRANT: begin
        if (rel_pulse || rel_drop || rel_hold) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // A timeout is only reported when the hold limit was the sole cause.
          timeout_d   = rel_hold && !rel_pulse && !rel_drop;
        end else begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_idx_q  <= last_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
